trap_sequencer: RTL and testbench

//  Multi-cycle machine-mode trap entry/exit sequencer beside the pipeline stall/flush controller.

---
 rtl/trap_sequencer_pkg.sv | 61 ++++++
 rtl/trap_sequencer_prio_enc.sv | 46 ++++
 rtl/trap_sequencer.sv | 168 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared constants, state encoding and types for the machine-mode trap sequencer.
package trap_sequencer_pkg;

    localparam int unsigned TS_XLEN   = 32;
    localparam int unsigned CSR_AW    = 12;
    localparam int unsigned EXC_W     = 32;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned STATE_W   = 3;

    // CSR addresses
    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342;

    // Mem-stage exception codes
    localparam logic [EXC_W-1:0] EXC_NONE    = 32'h0;
    localparam logic [EXC_W-1:0] EXC_ECALL   = 32'h8;
    localparam logic [EXC_W-1:0] EXC_ILLEGAL = 32'ha;
    localparam logic [EXC_W-1:0] EXC_MRET    = 32'he;

    // mcause low-order codes (interrupt flag carried separately)
    localparam logic [CODE_W-1:0] CODE_ECALL   = 4'd11;
    localparam logic [CODE_W-1:0] CODE_ILLEGAL = 4'd2;
    localparam logic [CODE_W-1:0] CODE_MEI     = 4'd11;
    localparam logic [CODE_W-1:0] CODE_MSI     = 4'd3;
    localparam logic [CODE_W-1:0] CODE_MTI     = 4'd7;

    // mstatus / mie bit positions
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP0 = 11;
    localparam int unsigned MSTATUS_MPP1 = 12;
    localparam int unsigned MIE_MSIE     = 3;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    // State encoding
    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_SAVE_EPC   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SAVE_CAUSE = 3'd2;
    localparam logic [STATE_W-1:0] ST_SAVE_STAT  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESTORE    = 3'd4;
    localparam logic [STATE_W-1:0] ST_REDIRECT   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = ST_IDLE,
        SAVE_EPC   = ST_SAVE_EPC,
        SAVE_CAUSE = ST_SAVE_CAUSE,
        SAVE_STAT  = ST_SAVE_STAT,
        RESTORE    = ST_RESTORE,
        REDIRECT   = ST_REDIRECT
    } state_t;

    // Priority-encoder result: trap taken, interrupt flag, cause code
    typedef struct packed {
        logic              take;
        logic              is_irq;
        logic [CODE_W-1:0] code;
    } trap_sel_t;

endpackage

// File: rtl/trap_sequencer_prio_enc.sv
// Trap priority select: sync exception > MEI > MSI > MTI.
module trap_prio_enc
    import trap_sequencer_pkg::*;
(
    input  logic [EXC_W-1:0] i_excepttype,
    input  logic             i_inst_valid,
    input  logic             i_irq_ext,
    input  logic             i_irq_sw,
    input  logic             i_irq_tmr,
    input  logic             i_mstatus_mie,
    input  logic             i_mie_meie,
    input  logic             i_mie_msie,
    input  logic             i_mie_mtie,
    output trap_sel_t        o_sel
);

    logic w_irq_ok;

    // A bubble cannot trap, and interrupts also need global MIE
    assign w_irq_ok = i_inst_valid & i_mstatus_mie;

    // Select the highest-priority trap source
    always_comb begin
        o_sel = '0;
        if (i_inst_valid && (i_excepttype == EXC_ECALL)) begin
            o_sel.take = 1'b1;
            o_sel.code = CODE_ECALL;
        end else if (i_inst_valid && (i_excepttype == EXC_ILLEGAL)) begin
            o_sel.take = 1'b1;
            o_sel.code = CODE_ILLEGAL;
        end else if (w_irq_ok && i_irq_ext && i_mie_meie) begin
            o_sel.take   = 1'b1;
            o_sel.is_irq = 1'b1;
            o_sel.code   = CODE_MEI;
        end else if (w_irq_ok && i_irq_sw && i_mie_msie) begin
            o_sel.take   = 1'b1;
            o_sel.is_irq = 1'b1;
            o_sel.code   = CODE_MSI;
        end else if (w_irq_ok && i_irq_tmr && i_mie_mtie) begin
            o_sel.take   = 1'b1;
            o_sel.is_irq = 1'b1;
            o_sel.code   = CODE_MTI;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: writes mepc, mcause, mstatus then flushes with redirect PC.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned       XLEN        = TS_XLEN,
    parameter logic [CSR_AW-1:0] CSR_MSTATUS = ADDR_MSTATUS,
    parameter logic [CSR_AW-1:0] CSR_MEPC    = ADDR_MEPC,
    parameter logic [CSR_AW-1:0] CSR_MCAUSE  = ADDR_MCAUSE
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [EXC_W-1:0]  excepttype_i,
    input  logic              inst_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              irq_ext_i,
    input  logic              irq_sw_i,
    input  logic              irq_tmr_i,
    input  logic [XLEN-1:0]   csr_mstatus_i,
    input  logic [XLEN-1:0]   csr_mie_i,
    input  logic [XLEN-1:0]   csr_mtvec_i,
    input  logic [XLEN-1:0]   csr_mepc_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              stallreq_o,
    output logic              flush_o,
    output logic [XLEN-1:0]   new_pc_o
);

    state_t          r_state;
    state_t          w_next;
    trap_sel_t       w_sel;
    logic            w_mret;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_stat_trap;
    logic [XLEN-1:0] w_stat_mret;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_mstatus;
    logic            w_unused;

    assign w_unused = ^csr_mie_i;

    trap_prio_enc u_prio (
        .i_excepttype  (excepttype_i),
        .i_inst_valid  (inst_valid_i),
        .i_irq_ext     (irq_ext_i),
        .i_irq_sw      (irq_sw_i),
        .i_irq_tmr     (irq_tmr_i),
        .i_mstatus_mie (csr_mstatus_i[MSTATUS_MIE]),
        .i_mie_meie    (csr_mie_i[MIE_MEIE]),
        .i_mie_msie    (csr_mie_i[MIE_MSIE]),
        .i_mie_mtie    (csr_mie_i[MIE_MTIE]),
        .o_sel         (w_sel)
    );

    assign w_mret  = inst_valid_i && (excepttype_i == EXC_MRET);
    assign w_cause = {w_sel.is_irq, (XLEN-1-CODE_W)'(0), w_sel.code};
    assign w_base  = {csr_mtvec_i[XLEN-1:2], 2'b00};

    // Vectored mode offsets interrupts by 4*code; modes 0/2/3 go to the base
    assign w_trap_target = ((csr_mtvec_i[1:0] == 2'b01) && w_sel.is_irq)
                         ? w_base + XLEN'({w_sel.code, 2'b00})
                         : w_base;

    // mstatus images for trap entry and for mret
    always_comb begin
        w_stat_trap               = r_mstatus;
        w_stat_trap[MSTATUS_MPIE] = r_mstatus[MSTATUS_MIE];
        w_stat_trap[MSTATUS_MIE]  = 1'b0;
        w_stat_trap[MSTATUS_MPP0] = 1'b1;
        w_stat_trap[MSTATUS_MPP1] = 1'b1;
        w_stat_mret               = r_mstatus;
        w_stat_mret[MSTATUS_MIE]  = r_mstatus[MSTATUS_MPIE];
        w_stat_mret[MSTATUS_MPIE] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture trap context while IDLE; inputs are ignored for the rest of a sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_cause   <= '0;
            r_target  <= '0;
            r_mstatus <= '0;
        end else if (r_state == IDLE) begin
            if (w_sel.take) begin
                r_pc      <= pc_i;
                r_cause   <= w_cause;
                r_target  <= w_trap_target;
                r_mstatus <= csr_mstatus_i;
            end else if (w_mret) begin
                r_target  <= csr_mepc_i;
                r_mstatus <= csr_mstatus_i;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next      = r_state;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        stallreq_o  = 1'b0;
        flush_o     = 1'b0;
        new_pc_o    = '0;
        case (r_state)
            IDLE: begin
                if (!rst && w_sel.take) begin
                    w_next     = SAVE_EPC;
                    stallreq_o = 1'b1;
                end else if (!rst && w_mret) begin
                    w_next     = RESTORE;
                    stallreq_o = 1'b1;
                end
            end
            SAVE_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = r_pc;
                stallreq_o  = 1'b1;
                w_next      = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = r_cause;
                stallreq_o  = 1'b1;
                w_next      = SAVE_STAT;
            end
            SAVE_STAT: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = w_stat_trap;
                stallreq_o  = 1'b1;
                w_next      = REDIRECT;
            end
            RESTORE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = w_stat_mret;
                stallreq_o  = 1'b1;
                w_next      = REDIRECT;
            end
            REDIRECT: begin
                flush_o  = 1'b1;
                new_pc_o = r_target;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_trap_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] excepttype;
    logic        inst_valid;
    logic [31:0] pc;
    logic        irq_ext, irq_sw, irq_tmr;
    logic [31:0] mstatus, mie, mtvec, mepc;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stallreq, flush;
    logic [31:0] new_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        stall;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    trap_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .excepttype_i  (excepttype),
        .inst_valid_i  (inst_valid),
        .pc_i          (pc),
        .irq_ext_i     (irq_ext),
        .irq_sw_i      (irq_sw),
        .irq_tmr_i     (irq_tmr),
        .csr_mstatus_i (mstatus),
        .csr_mie_i     (mie),
        .csr_mtvec_i   (mtvec),
        .csr_mepc_i    (mepc),
        .csr_we_o      (csr_we),
        .csr_waddr_o   (csr_waddr),
        .csr_wdata_o   (csr_wdata),
        .stallreq_o    (stallreq),
        .flush_o       (flush),
        .new_pc_o      (new_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [11:0] addr, input logic [31:0] data,
                                input logic stall, input logic fl, input logic [31:0] npc);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.stall = stall; e.flush = fl; e.pc = npc;
        return e;
    endfunction

    // Model: decide from the architectural rules what this IDLE cycle does and queue the resulting cycles
    task automatic model_idle_cycle();
        logic        trap, irq, mret_go;
        logic [31:0] cause, base, target, ms_new;
        logic [3:0]  code;
        trap = 1'b0; irq = 1'b0; code = 4'd0;
        if (inst_valid && excepttype == 32'h8) begin
            trap = 1'b1; code = 4'd11;
        end else if (inst_valid && excepttype == 32'ha) begin
            trap = 1'b1; code = 4'd2;
        end else if (inst_valid && mstatus[3]) begin
            if (irq_ext && mie[11])     begin trap = 1'b1; irq = 1'b1; code = 4'd11; end
            else if (irq_sw && mie[3])  begin trap = 1'b1; irq = 1'b1; code = 4'd3;  end
            else if (irq_tmr && mie[7]) begin trap = 1'b1; irq = 1'b1; code = 4'd7;  end
        end
        mret_go = !trap && inst_valid && (excepttype == 32'he);
        chk("idle_stall", {31'b0, stallreq}, {31'b0, trap | mret_go});
        chk("idle_we", {31'b0, csr_we}, 32'd0);
        chk("idle_flush", {31'b0, flush}, 32'd0);
        if (trap) begin
            cause  = irq ? (32'h8000_0000 | {28'b0, code}) : {28'b0, code};
            base   = mtvec & ~32'h3;
            target = (irq && mtvec[1:0] == 2'b01) ? base + 32'd4 * {28'b0, code} : base;
            ms_new = (mstatus & ~32'h0000_1888) | (mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
            exp_q.push_back(mk(1'b1, 12'h341, pc, 1'b1, 1'b0, 32'h0));
            exp_q.push_back(mk(1'b1, 12'h342, cause, 1'b1, 1'b0, 32'h0));
            exp_q.push_back(mk(1'b1, 12'h300, ms_new, 1'b1, 1'b0, 32'h0));
            exp_q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b0, 1'b1, target));
        end else if (mret_go) begin
            ms_new = (mstatus & ~32'h0000_0088) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
            exp_q.push_back(mk(1'b1, 12'h300, ms_new, 1'b1, 1'b0, 32'h0));
            exp_q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b0, 1'b1, mepc));
        end
    endtask

    // Compare process: every cycle, sampled mid-cycle on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_we", {31'b0, csr_we}, 32'd0);
            chk("rst_stall", {31'b0, stallreq}, 32'd0);
            chk("rst_flush", {31'b0, flush}, 32'd0);
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seq_we", {31'b0, csr_we}, {31'b0, e.we});
            if (e.we) begin
                chk("seq_addr", {20'b0, csr_waddr}, {20'b0, e.addr});
                chk("seq_data", csr_wdata, e.data);
            end
            chk("seq_stall", {31'b0, stallreq}, {31'b0, e.stall});
            chk("seq_flush", {31'b0, flush}, {31'b0, e.flush});
            if (e.flush) chk("seq_new_pc", new_pc, e.pc);
        end else begin
            model_idle_cycle();
        end
    end

    task automatic set_idle();
        excepttype = 32'h0; inst_valid = 1'b0; pc = 32'h0;
        irq_ext = 1'b0; irq_sw = 1'b0; irq_tmr = 1'b0;
        mstatus = 32'h0; mie = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_write(input string nm, input logic [11:0] addr, input logic [31:0] data);
        chk({nm, "_we"}, {31'b0, csr_we}, 32'd1);
        chk({nm, "_addr"}, {20'b0, csr_waddr}, {20'b0, addr});
        chk({nm, "_data"}, csr_wdata, data);
    endtask

    task automatic lit_flush(input string nm, input logic [31:0] npc);
        chk({nm, "_flush"}, {31'b0, flush}, 32'd1);
        chk({nm, "_stall"}, {31'b0, stallreq}, 32'd0);
        chk({nm, "_new_pc"}, new_pc, npc);
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", {31'b0, csr_we}, 32'd0);
        chk("reset_addr", {20'b0, csr_waddr}, 32'd0);
        chk("reset_data", csr_wdata, 32'd0);
        chk("reset_flush", {31'b0, flush}, 32'd0);
        chk("reset_new_pc", new_pc, 32'd0);
        tick(); rst = 1'b0;

        // ecall, direct mtvec
        tick(); excepttype = 32'h8; inst_valid = 1'b1; pc = 32'h100; mtvec = 32'h40; mstatus = 32'h8;
        #3 chk("ecall_stall", {31'b0, stallreq}, 32'd1);
        tick(); set_idle(); #3 lit_write("ecall_mepc", 12'h341, 32'h100);
        tick(); #3 lit_write("ecall_mcause", 12'h342, 32'd11);
        tick(); #3 lit_write("ecall_mstatus", 12'h300, 32'h1880);
        tick(); #3 lit_flush("ecall", 32'h40);

        // timer interrupt, vectored
        tick(); mstatus = 32'h8; mie = 32'h80; irq_tmr = 1'b1; inst_valid = 1'b1; mtvec = 32'h41; pc = 32'h300;
        #3 chk("mti_stall", {31'b0, stallreq}, 32'd1);
        tick(); set_idle(); #3 lit_write("mti_mepc", 12'h341, 32'h300);
        tick(); #3 lit_write("mti_mcause", 12'h342, 32'h8000_0007);
        tick();
        tick(); #3 lit_flush("mti", 32'h5C);

        // timer interrupt masked by MIE=0
        tick(); mstatus = 32'h0; mie = 32'h80; irq_tmr = 1'b1; inst_valid = 1'b1; mtvec = 32'h41;
        #3 chk("mti_masked_stall", {31'b0, stallreq}, 32'd0);
        tick(); #3 chk("mti_masked_we", {31'b0, csr_we}, 32'd0);
        set_idle();

        // illegal + MEI together: exception first, interrupt stays pending
        tick(); excepttype = 32'ha; inst_valid = 1'b1; irq_ext = 1'b1; mie = 32'h800; mstatus = 32'h8;
        mtvec = 32'h41; pc = 32'h400;
        #3 chk("sim_stall", {31'b0, stallreq}, 32'd1);
        tick(); #3 lit_write("sim_mepc", 12'h341, 32'h400);
        tick(); #3 lit_write("sim_mcause", 12'h342, 32'd2);
        tick();
        tick(); #3 lit_flush("sim", 32'h40);
        // handler returns with mret (MIE=0 in the handler, MPIE=1)
        tick(); excepttype = 32'he; inst_valid = 1'b1; mepc = 32'h204; mstatus = 32'h80;
        #3 chk("mret_stall", {31'b0, stallreq}, 32'd1);
        tick(); #3 lit_write("mret_mstatus", 12'h300, 32'h88);
        tick(); #3 lit_flush("mret", 32'h204);
        // pending MEI now taken
        tick(); excepttype = 32'h0; inst_valid = 1'b1; mstatus = 32'h8; mie = 32'h800; irq_ext = 1'b1;
        mtvec = 32'h41; pc = 32'h204;
        tick(); tick(); #3 lit_write("mei_mcause", 12'h342, 32'h8000_000B);
        tick();
        tick(); #3 lit_flush("mei", 32'h6C);
        set_idle();

        // reset during SAVE_CAUSE aborts the sequence
        tick(); excepttype = 32'h8; inst_valid = 1'b1; pc = 32'h500; mtvec = 32'h40; mstatus = 32'h8;
        tick(); set_idle();
        tick(); #1 lit_write("abort_pre", 12'h342, 32'd11);
        rst = 1'b1;
        #1;
        chk("abort_we", {31'b0, csr_we}, 32'd0);
        chk("abort_stall", {31'b0, stallreq}, 32'd0);
        chk("abort_addr", {20'b0, csr_waddr}, 32'd0);
        tick(); tick(); rst = 1'b0;
        #3 chk("abort_post_we", {31'b0, csr_we}, 32'd0);
        tick(); #3 chk("abort_post_we2", {31'b0, csr_we}, 32'd0);

        // bubble holds off an external interrupt
        tick(); inst_valid = 1'b0; irq_ext = 1'b1; mie = 32'h800; mstatus = 32'h8; mtvec = 32'h41; pc = 32'h600;
        #3 chk("bubble_stall", {31'b0, stallreq}, 32'd0);
        tick(); #3 chk("bubble_stall2", {31'b0, stallreq}, 32'd0);
        tick(); inst_valid = 1'b1;
        #3 chk("bubble_valid_stall", {31'b0, stallreq}, 32'd1);
        tick(); tick(); tick();
        tick(); #3 lit_flush("bubble", 32'h6C);
        set_idle();

        // random traffic, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            tick();
            inst_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: excepttype = 32'h8;
                1: excepttype = 32'ha;
                2: excepttype = 32'he;
                3: excepttype = 32'h3;
                default: excepttype = 32'h0;
            endcase
            if (!inst_valid && excepttype != 32'he) excepttype = 32'h0;
            pc      = $urandom();
            irq_ext = ($urandom_range(0, 5) == 0);
            irq_sw  = ($urandom_range(0, 5) == 0);
            irq_tmr = ($urandom_range(0, 5) == 0);
            mstatus = $urandom();
            mie     = $urandom();
            mtvec   = $urandom();
            if ($urandom_range(0, 1) == 1) mtvec = {mtvec[31:2], 2'b01};
            mepc    = $urandom();
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        tick(); set_idle();
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
